// File: rtl/mem_arbiter.sv
// Unified memory-port arbiter: data-first priority with an anti-starvation counter for fetches.
// Define ARB_TIMEOUT_EN to add a MemAck watchdog that raises BusError and releases the grant.
module mem_arbiter #(
  parameter int WIDTH        = 32,
  parameter int STARVE_LIMIT = 4
`ifdef ARB_TIMEOUT_EN
  ,
  parameter int TIMEOUT      = 64
`endif
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] PC,
  input  logic             InstrMemReadEnable,
  output logic             InstrMemAck,
  output logic [WIDTH-1:0] Instr,
  input  logic [WIDTH-1:0] DataMemReadAddress,
  input  logic [WIDTH-1:0] DataMemWriteData,
  input  logic             DataMemReadEnable,
  input  logic             DataMemWriteEnable,
  input  logic [3:0]       DataMemByteEnable,
  output logic             DataMemAck,
  output logic [WIDTH-1:0] DataMemReadData,
  output logic [WIDTH-1:0] MemAddress,
  output logic [WIDTH-1:0] MemWriteData,
  output logic             MemReadEnable,
  output logic             MemWriteEnable,
  output logic [3:0]       MemByteEnable,
  input  logic             MemAck,
  input  logic [WIDTH-1:0] MemReadData,
  output logic             BusError
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } state_t;

  localparam int            SW         = $clog2(STARVE_LIMIT + 2);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  state_t        r_state;
  state_t        w_state_next;
  logic [SW-1:0] r_starve;
  logic [SW-1:0] w_starve_next;
  logic          w_dreq;
  logic          w_ireq;
  logic          w_timeout;

  assign w_dreq = DataMemReadEnable | DataMemWriteEnable;
  assign w_ireq = InstrMemReadEnable;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state  <= IDLE;
      r_starve <= '0;
    end else begin
      r_state  <= w_state_next;
      r_starve <= w_starve_next;
    end
  end

`ifdef ARB_TIMEOUT_EN
  localparam int            TW        = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] WDOG_LAST = TW'(TIMEOUT - 1);

  logic [TW-1:0] r_wdog;

  // Counts cycles of the current grant; every grant starts from IDLE, so IDLE is the restart point.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_wdog <= '0;
    end else if (r_state == IDLE) begin
      r_wdog <= '0;
    end else begin
      r_wdog <= r_wdog + 1'b1;
    end
  end

  assign w_timeout = (r_state != IDLE) && (r_wdog == WDOG_LAST) && !MemAck;
`else
  assign w_timeout = 1'b0;
`endif

  assign BusError = w_timeout;

  always_comb begin
    w_state_next    = r_state;
    w_starve_next   = r_starve;
    MemAddress      = '0;
    MemWriteData    = '0;
    MemReadEnable   = 1'b0;
    MemWriteEnable  = 1'b0;
    MemByteEnable   = 4'b0000;
    InstrMemAck     = 1'b0;
    Instr           = '0;
    DataMemAck      = 1'b0;
    DataMemReadData = '0;
    case (r_state)
      IDLE: begin
        // A waiting fetch that has been overtaken STARVE_LIMIT times wins the next tie.
        if (w_dreq && !(w_ireq && (r_starve == STARVE_MAX))) begin
          w_state_next  = SERVE_D;
          w_starve_next = w_ireq ? r_starve + 1'b1 : '0;
        end else if (w_ireq) begin
          w_state_next  = SERVE_I;
          w_starve_next = '0;
        end else begin
          w_starve_next = '0;
        end
      end
      SERVE_I: begin
        MemAddress    = PC;
        MemReadEnable = 1'b1;
        MemByteEnable = 4'b1111;
        InstrMemAck   = MemAck;
        Instr         = MemReadData;
        if (MemAck || w_timeout) begin
          w_state_next = IDLE;
        end
      end
      SERVE_D: begin
        MemAddress      = DataMemReadAddress;
        MemWriteData    = DataMemWriteData;
        MemReadEnable   = DataMemReadEnable;
        MemWriteEnable  = DataMemWriteEnable;
        MemByteEnable   = DataMemByteEnable;
        DataMemAck      = MemAck;
        DataMemReadData = MemReadData;
        if (MemAck || w_timeout) begin
          w_state_next = IDLE;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios with literal expectations, then
// randomized requesters/memory checked every cycle against a grant-level model.
module tb_mem_arbiter;

  localparam int W  = 32;
  localparam int SL = 4;
`ifdef ARB_TIMEOUT_EN
  localparam int TO = 8;
`endif

  logic         CLK = 1'b0;
  logic         RST = 1'b1;
  logic [W-1:0] PC = '0;
  logic         InstrMemReadEnable = 1'b0;
  logic         InstrMemAck;
  logic [W-1:0] Instr;
  logic [W-1:0] DataMemReadAddress = '0;
  logic [W-1:0] DataMemWriteData = '0;
  logic         DataMemReadEnable = 1'b0;
  logic         DataMemWriteEnable = 1'b0;
  logic [3:0]   DataMemByteEnable = 4'b0000;
  logic         DataMemAck;
  logic [W-1:0] DataMemReadData;
  logic [W-1:0] MemAddress;
  logic [W-1:0] MemWriteData;
  logic         MemReadEnable;
  logic         MemWriteEnable;
  logic [3:0]   MemByteEnable;
  logic         MemAck = 1'b0;
  logic [W-1:0] MemReadData = '0;
  logic         BusError;

  mem_arbiter #(
    .WIDTH(W),
    .STARVE_LIMIT(SL)
`ifdef ARB_TIMEOUT_EN
    ,
    .TIMEOUT(TO)
`endif
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .PC(PC),
    .InstrMemReadEnable(InstrMemReadEnable),
    .InstrMemAck(InstrMemAck),
    .Instr(Instr),
    .DataMemReadAddress(DataMemReadAddress),
    .DataMemWriteData(DataMemWriteData),
    .DataMemReadEnable(DataMemReadEnable),
    .DataMemWriteEnable(DataMemWriteEnable),
    .DataMemByteEnable(DataMemByteEnable),
    .DataMemAck(DataMemAck),
    .DataMemReadData(DataMemReadData),
    .MemAddress(MemAddress),
    .MemWriteData(MemWriteData),
    .MemReadEnable(MemReadEnable),
    .MemWriteEnable(MemWriteEnable),
    .MemByteEnable(MemByteEnable),
    .MemAck(MemAck),
    .MemReadData(MemReadData),
    .BusError(BusError)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Model: who owns the port (0 none, 1 fetch, 2 data), how many data grants in a row
  // overtook a waiting fetch, and how many cycles the current grant has lasted.
  int m_grant  = 0;
  int m_streak = 0;
  int m_age    = 0;
  bit m_d, m_i;

  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      m_grant = 0; m_streak = 0; m_age = 0;
    end else if (m_grant == 0) begin
      m_d = DataMemReadEnable | DataMemWriteEnable;
      m_i = InstrMemReadEnable;
      if (m_d && !(m_i && m_streak == SL)) begin
        m_grant  = 2;
        m_streak = m_i ? m_streak + 1 : 0;
      end else if (m_i) begin
        m_grant  = 1;
        m_streak = 0;
      end else begin
        m_streak = 0;
      end
      m_age = (m_grant != 0) ? 1 : 0;
    end else if (MemAck) begin
      m_grant = 0;
`ifdef ARB_TIMEOUT_EN
    end else if (m_age == TO) begin
      m_grant = 0;
`endif
    end else begin
      m_age++;
    end
  end

  logic [W-1:0] e_addr, e_wd, e_instr, e_rdata;
  logic         e_re, e_we, e_iack, e_dack, e_berr;
  logic [3:0]   e_be;

  always @(negedge CLK) begin
    e_addr = '0; e_wd = '0; e_re = 1'b0; e_we = 1'b0; e_be = 4'b0000;
    e_iack = 1'b0; e_instr = '0; e_dack = 1'b0; e_rdata = '0; e_berr = 1'b0;
    if (m_grant == 1) begin
      e_addr = PC; e_re = 1'b1; e_be = 4'b1111; e_iack = MemAck; e_instr = MemReadData;
    end else if (m_grant == 2) begin
      e_addr = DataMemReadAddress; e_wd = DataMemWriteData; e_re = DataMemReadEnable;
      e_we = DataMemWriteEnable; e_be = DataMemByteEnable; e_dack = MemAck; e_rdata = MemReadData;
    end
`ifdef ARB_TIMEOUT_EN
    if (m_grant != 0 && m_age == TO && !MemAck) e_berr = 1'b1;
`endif
    check("mem_bus", {MemAddress, MemWriteData, MemReadEnable, MemWriteEnable, MemByteEnable},
          {e_addr, e_wd, e_re, e_we, e_be});
    check("fetch_port", {InstrMemAck, Instr}, {e_iack, e_instr});
    check("data_port", {DataMemAck, DataMemReadData}, {e_dack, e_rdata});
    check("bus_error", BusError, e_berr);
  end

  task automatic next_cycle();
    @(posedge CLK);
    #2;
  endtask

  logic [9:0] seq;
  int         ng;
  bit         i_done, d_done, busy;
  int         lat, kind;

  initial begin
    repeat (3) @(posedge CLK);
    #2 RST = 1'b0;
    next_cycle();

    // Isolated fetch, memory acks in cycle 3.
    PC = 32'h100; InstrMemReadEnable = 1'b1;
    @(negedge CLK); check("fetch_c0_idle", MemReadEnable, 1'b0);
    for (int c = 1; c <= 3; c++) begin
      next_cycle();
      MemAck = (c == 3); MemReadData = (c == 3) ? 32'hDEADBEEF : 32'h0;
      @(negedge CLK);
      check("fetch_strobe", {MemReadEnable, MemByteEnable, MemAddress}, {1'b1, 4'b1111, 32'h100});
      check("fetch_no_dack", DataMemAck, 1'b0);
      if (c == 3) check("fetch_ack", {InstrMemAck, Instr}, {1'b1, 32'hDEADBEEF});
    end
    next_cycle();
    InstrMemReadEnable = 1'b0; MemAck = 1'b0; MemReadData = '0;
    @(negedge CLK);
    check("fetch_c4_idle", MemReadEnable, 1'b0);
    check("model_idle_after_fetch", m_grant, 0);

    // Simultaneous requests with a single-cycle memory.
    next_cycle();
    PC = 32'h300; InstrMemReadEnable = 1'b1;
    DataMemReadAddress = 32'h200; DataMemReadEnable = 1'b1; DataMemByteEnable = 4'b1111;
    next_cycle();
    MemAck = 1'b1; MemReadData = 32'h0BAD_F00D;
    @(negedge CLK);
    check("simul_data_first", {MemAddress, DataMemAck, DataMemReadData, InstrMemAck},
          {32'h200, 1'b1, 32'h0BAD_F00D, 1'b0});
    next_cycle();
    DataMemReadEnable = 1'b0; MemAck = 1'b0;
    @(negedge CLK); check("simul_bubble", MemReadEnable, 1'b0);
    next_cycle();
    MemAck = 1'b1; MemReadData = 32'h1234_0000;
    @(negedge CLK);
    check("simul_fetch_second", {MemAddress, InstrMemAck, Instr}, {32'h300, 1'b1, 32'h1234_0000});
    next_cycle();
    InstrMemReadEnable = 1'b0; MemAck = 1'b0;

    // Starvation: both requests held, memory acks every granted cycle.
    next_cycle();
    InstrMemReadEnable = 1'b1; DataMemReadEnable = 1'b1;
    seq = '0; ng = 0;
    for (int c = 0; c < 30 && ng < 10; c++) begin
      @(negedge CLK);
      if (DataMemAck || InstrMemAck) begin
        seq = {seq[8:0], InstrMemAck};
        ng++;
      end
      next_cycle();
      MemAck = MemReadEnable | MemWriteEnable;
    end
    check("starve_grants", ng, 10);
    check("starve_pattern", seq, 10'b0000100001);
    InstrMemReadEnable = 1'b0; DataMemReadEnable = 1'b0; MemAck = 1'b0;
    next_cycle();
    next_cycle();

    // Store passthrough.
    DataMemWriteEnable = 1'b1; DataMemByteEnable = 4'b0011;
    DataMemWriteData = 32'h12345678; DataMemReadAddress = 32'h40;
    next_cycle();
    @(negedge CLK);
    check("store_pass", {MemAddress, MemWriteData, MemReadEnable, MemWriteEnable, MemByteEnable, DataMemAck},
          {32'h40, 32'h12345678, 1'b0, 1'b1, 4'b0011, 1'b0});
    next_cycle();
    MemAck = 1'b1;
    @(negedge CLK); check("store_ack", DataMemAck, 1'b1);
    next_cycle();
    DataMemWriteEnable = 1'b0; MemAck = 1'b0;

    // Reset during SERVE_D, then a late MemAck.
    next_cycle();
    DataMemReadEnable = 1'b1; DataMemReadAddress = 32'h80; MemReadData = 32'hAAAA_5555;
    next_cycle();
    @(negedge CLK); check("rst_pre_grant", MemReadEnable, 1'b1);
    next_cycle();
    RST = 1'b1; DataMemReadEnable = 1'b0;
    #1;
    check("rst_immediate", {MemAddress, MemWriteData, MemReadEnable, MemWriteEnable, MemByteEnable,
                            DataMemAck, DataMemReadData, InstrMemAck, Instr}, 128'h0);
    next_cycle();
    RST = 1'b0;
    next_cycle();
    MemAck = 1'b1;
    @(negedge CLK); check("rst_late_ack_ignored", {DataMemAck, MemReadEnable, DataMemReadData}, 34'h0);
    next_cycle();
    MemAck = 1'b0;

`ifdef ARB_TIMEOUT_EN
    // Watchdog: memory never acks a fetch.
    next_cycle();
    PC = 32'h500; InstrMemReadEnable = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      next_cycle();
      MemAck = (c == 10);
      @(negedge CLK);
      check("wdog_buserror", BusError, (c == 8));
      if (c < 10) check("wdog_no_iack", InstrMemAck, 1'b0);
      if (c == 9) check("wdog_bubble", MemReadEnable, 1'b0);
      if (c == 10) check("wdog_regrant", {MemReadEnable, InstrMemAck}, 2'b11);
    end
    next_cycle();
    InstrMemReadEnable = 1'b0; MemAck = 1'b0;
`endif

    // Randomized requesters and variable-latency memory with stray acks.
    busy = 1'b0; lat = 0;
    repeat (3000) begin
      @(negedge CLK);
      i_done = InstrMemAck; d_done = DataMemAck;
      @(posedge CLK);
      #1;
      if (i_done) InstrMemReadEnable = 1'b0;
      if (!InstrMemReadEnable && $urandom_range(0, 2) == 0) begin
        InstrMemReadEnable = 1'b1; PC = $urandom;
      end
      if (d_done) begin DataMemReadEnable = 1'b0; DataMemWriteEnable = 1'b0; end
      if (!(DataMemReadEnable | DataMemWriteEnable) && $urandom_range(0, 1) == 0) begin
        kind = $urandom_range(0, 3);
        DataMemReadEnable  = (kind != 1);
        DataMemWriteEnable = (kind == 1) || (kind == 3);
        DataMemReadAddress = $urandom; DataMemWriteData = $urandom;
        DataMemByteEnable  = 4'($urandom_range(0, 15));
      end
      #1;
      if (MemReadEnable | MemWriteEnable) begin
        if (!busy) begin busy = 1'b1; lat = $urandom_range(0, 3); end
        if (lat == 0) begin MemAck = 1'b1; busy = 1'b0; end
        else begin MemAck = 1'b0; lat--; end
      end else begin
        busy = 1'b0;
        MemAck = ($urandom_range(0, 7) == 0);
      end
      MemReadData = $urandom;
    end

    next_cycle();
    InstrMemReadEnable = 1'b0; DataMemReadEnable = 1'b0; DataMemWriteEnable = 1'b0; MemAck = 1'b0;
    repeat (4) next_cycle();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Shares one unified memory port between the core's instruction-fetch and data-access ports.
- Sits between the core and a single memory model, replacing the separate I/D memories.
- Arbitrates using data-first priority with an anti-starvation counter.
- Forwards the enable/ack handshake and read data to whichever requester holds the grant.

Parameters:
WIDTH, 32, address and data width in bits
STARVE_LIMIT, 4, consecutive data grants allowed while an instruction request waits before the instruction port is forced
TIMEOUT, 64, cycles allowed for MemAck before the watchdog aborts (used only with ARB_TIMEOUT_EN)

Ports:
CLK  input  1  clock, rising edge
RST  input  1  reset, asynchronous, active-high
PC  input  WIDTH  instruction fetch address
InstrMemReadEnable  input  1  fetch request; held high until InstrMemAck
InstrMemAck  output  1  one-cycle fetch completion pulse
Instr  output  WIDTH  fetched word; valid while InstrMemAck=1
DataMemReadAddress  input  WIDTH  data access address
DataMemWriteData  input  WIDTH  store data
DataMemReadEnable  input  1  load request; held until DataMemAck
DataMemWriteEnable  input  1  store request; held until DataMemAck
DataMemByteEnable  input  4  store/load byte lanes
DataMemAck  output  1  one-cycle data completion pulse
DataMemReadData  output  WIDTH  load data; valid while DataMemAck=1
MemAddress  output  WIDTH  shared memory address
MemWriteData  output  WIDTH  shared memory write data
MemReadEnable  output  1  shared memory read strobe (level)
MemWriteEnable  output  1  shared memory write strobe (level)
MemByteEnable  output  4  shared memory byte lanes
MemAck  input  1  shared memory one-cycle completion pulse
MemReadData  input  WIDTH  shared memory read data
BusError  output  1  one-cycle pulse on watchdog abort

Behaviour:
- Reset:
  - State IDLE; starvation counter 0; watchdog 0.
  - All outputs 0, including MemAddress, MemWriteData and MemByteEnable.
  - RST mid-transaction aborts immediately. A MemAck arriving afterwards is ignored: in IDLE, acks are never forwarded.
- States: IDLE, SERVE_I, SERVE_D.
- IDLE:
  - Mem enables 0; Mem buses 0.
  - dreq = DataMemReadEnable | DataMemWriteEnable; ireq = InstrMemReadEnable.
  - dreq & ireq: go to SERVE_I if the starvation counter equals STARVE_LIMIT, else SERVE_D.
  - dreq only: go to SERVE_D. ireq only: go to SERVE_I. Neither: stay in IDLE.
- SERVE_I:
  - MemAddress = PC; MemReadEnable = 1; MemWriteEnable = 0; MemByteEnable = 4'b1111; MemWriteData = 0.
  - InstrMemAck = MemAck (combinational); Instr = MemReadData.
  - On MemAck, go to IDLE.
- SERVE_D:
  - Data address, write data, enables and byte lanes are passed through unchanged, combinationally. Read and write enables both high is forwarded as-is.
  - DataMemAck = MemAck; DataMemReadData = MemReadData.
  - On MemAck, go to IDLE.
- Requester outputs: the non-granted requester's ack is 0 and its read data is 0.
- Starvation counter (saturating):
  - Increments on entering SERVE_D while ireq = 1.
  - Clears on entering SERVE_I.
  - Clears when ireq = 0 in IDLE.
- Latency:
  - Request visible in IDLE at cycle 0; memory strobes asserted from cycle 1; requester ack in the same cycle as MemAck.
  - Every transaction is followed by exactly one IDLE cycle with strobes low. This bubble guarantees a requester's stale enable in the ack cycle is never re-granted.
- Ack behaviour: MemAck in IDLE is ignored. Once a grant is issued it is held until ack; no preemption.

Optional Feature:
ARB_TIMEOUT_EN
- Defined:
  - The watchdog counts cycles spent in SERVE_I or SERVE_D and resets on every state entry.
  - When the count reaches TIMEOUT without MemAck, the block pulses BusError for one cycle, sends no requester ack, and returns to IDLE.
  - The requester's enable is still high, so that request re-arbitrates normally.
- Undefined: no watchdog logic; BusError tied to 0.

Test Plan:
- Isolated fetch: PC=0x100, InstrMemReadEnable=1 in cycle 0; memory acks in cycle 3 with 0xDEADBEEF.
  -> MemReadEnable=1 in cycles 1-3, MemByteEnable=1111, InstrMemAck=1 with Instr=0xDEADBEEF in cycle 3, IDLE in cycle 4, DataMemAck never 1.
- Simultaneous requests: both ports assert in cycle 0 with a 1-cycle memory.
  -> Data transaction served first (MemAddress=DataMemReadAddress in cycle 1), bubble in cycle 2, instruction served in cycle 3.
- Starvation: ireq held high while dreq is re-asserted every IDLE, STARVE_LIMIT=4.
  -> Exactly 4 SERVE_D grants, then SERVE_I, counter back to 0.
- Store passthrough: DataMemWriteEnable=1, DataMemByteEnable=0011, data 0x12345678, address 0x40.
  -> Mem outputs carry identical values, MemReadEnable=0, DataMemAck on MemAck.
- Reset mid-transaction: RST asserted during SERVE_D, then MemAck pulses after release.
  -> All outputs 0 immediately, no DataMemAck, state IDLE.
- ARB_TIMEOUT_EN, TIMEOUT=8, memory never acks a fetch.
  -> BusError pulse in cycle 8 after grant, InstrMemAck stays 0, re-grant to the instruction port after one IDLE cycle.
